// File: rtl/tdm_demux5_pkg.sv
// rtl/tdm_demux5_pkg.sv - shared constants, state encoding and helpers for the TDM demux
package tdm_demux5_pkg;

  localparam int NCH = 5;

  localparam logic [2:0] SLOT_U = 3'd0;
  localparam logic [2:0] SLOT_V = 3'd1;
  localparam logic [2:0] SLOT_W = 3'd2;
  localparam logic [2:0] SLOT_X = 3'd3;
  localparam logic [2:0] SLOT_Y = 3'd4;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RECV = 1'b1
  } state_t;

  function automatic int unsigned beats_per_group(input int unsigned width);
    return NCH * width;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - slot/bit counter pair for a 5-slot TDM frame
module tdm_slot_ctr
  import tdm_demux5_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_restart,
  input  logic          i_adv,
  output logic [2:0]    o_slot,
  output logic [BW-1:0] o_bit,
  output logic          o_first,
  output logic          o_last
);

  logic [2:0]    r_slot;
  logic [BW-1:0] r_bit;

  // A restart beat is itself beat 0, so the counters land on the beat after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot <= SLOT_U;
      r_bit  <= '0;
    end else if (i_restart) begin
      r_slot <= SLOT_V;
      r_bit  <= '0;
    end else if (i_adv) begin
      if (r_slot == SLOT_Y) begin
        r_slot <= SLOT_U;
        r_bit  <= (r_bit == BW'(WIDTH - 1)) ? '0 : r_bit + 1'b1;
      end else begin
        r_slot <= r_slot + 3'd1;
      end
    end
  end

  assign o_slot  = r_slot;
  assign o_bit   = r_bit;
  assign o_first = (r_slot == SLOT_U) && (r_bit == '0);
  assign o_last  = (r_slot == SLOT_Y) && (r_bit == BW'(WIDTH - 1));

endmodule

// File: rtl/tdm_demux5.sv
// rtl/tdm_demux5.sv - 5-channel TDM receiver with frame sync, valid/ready output and overrun flag
module tdm_demux5
  import tdm_demux5_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m,
  input  logic             m_vld,
  input  logic             sync,
  output logic [WIDTH-1:0] u_o,
  output logic [WIDTH-1:0] v_o,
  output logic [WIDTH-1:0] w_o,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             sync_err,
  output logic             ovf
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sr   [NCH];
  logic [WIDTH-1:0] r_word [NCH];
  logic             r_out_vld;
  logic             r_sync_err;
  logic             r_ovf;

  logic             w_restart;
  logic             w_slip;
  logic             w_shift;
  logic             w_load;
  logic             w_adv;
  logic [2:0]       w_slot;
  logic [2:0]       w_sel;
  logic [BW-1:0]    w_bit;
  logic             w_first;
  logic             w_last;

  tdm_slot_ctr #(.WIDTH(WIDTH), .BW(BW)) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .i_adv     (w_adv),
    .o_slot    (w_slot),
    .o_bit     (w_bit),
    .o_first   (w_first),
    .o_last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_HUNT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_slip      = 1'b0;
    w_shift     = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (m_vld && sync) begin
          w_state_nxt = ST_RECV;
          w_restart   = 1'b1;
          w_shift     = 1'b1;
        end
      end
      ST_RECV: begin
        if (m_vld) begin
          w_shift = 1'b1;
          // A misplaced sync wins over completion: the group is abandoned.
          if (sync && !w_first) begin
            w_restart = 1'b1;
            w_slip    = 1'b1;
          end else if (w_last) begin
            w_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  assign w_adv = (r_state == ST_RECV) && m_vld && !w_restart;
  assign w_sel = w_restart ? SLOT_U : w_slot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) r_sr[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (w_shift && (w_sel == 3'(i))) r_sr[i] <= {r_sr[i][WIDTH-2:0], m};
      end
    end
  end

  // The completing beat is always a y-slot bit, so y takes it straight from m.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) r_word[i] <= '0;
      r_out_vld  <= 1'b0;
      r_sync_err <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_sync_err <= w_slip;
      if (w_load) begin
        r_word[SLOT_U] <= r_sr[SLOT_U];
        r_word[SLOT_V] <= r_sr[SLOT_V];
        r_word[SLOT_W] <= r_sr[SLOT_W];
        r_word[SLOT_X] <= r_sr[SLOT_X];
        r_word[SLOT_Y] <= {r_sr[SLOT_Y][WIDTH-2:0], m};
        r_out_vld      <= 1'b1;
        if (r_out_vld && !out_rdy) r_ovf <= 1'b1;
      end else if (r_out_vld && out_rdy) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign u_o      = r_word[SLOT_U];
  assign v_o      = r_word[SLOT_V];
  assign w_o      = r_word[SLOT_W];
  assign x_o      = r_word[SLOT_X];
  assign y_o      = r_word[SLOT_Y];
  assign out_vld  = r_out_vld;
  assign sync_err = r_sync_err;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_tdm_demux5.sv
// tb/tb_tdm_demux5.sv - directed self-checking bench for tdm_demux5
module tb_tdm_demux5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m;
  logic       m_vld;
  logic       sync;
  logic [7:0] u_o, v_o, w_o, x_o, y_o;
  logic       out_vld;
  logic       out_rdy;
  logic       sync_err;
  logic       ovf;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  tdm_demux5 #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .m        (m),
    .m_vld    (m_vld),
    .sync     (sync),
    .u_o      (u_o),
    .v_o      (v_o),
    .w_o      (w_o),
    .x_o      (x_o),
    .y_o      (y_o),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .sync_err (sync_err),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_beat(input logic b, input logic s);
    m     = b;
    sync  = s;
    m_vld = 1'b1;
    step();
    m_vld = 1'b0;
    sync  = 1'b0;
  endtask

  task automatic idle();
    m_vld = 1'b0;
    sync  = 1'b0;
    step();
  endtask

  // Sends n_beats beats of one frame (slot-major interleave, MSB first).
  task automatic send_frame(input logic [7:0] wu, input logic [7:0] wv, input logic [7:0] ww,
                            input logic [7:0] wx, input logic [7:0] wy, input bit first_sync,
                            input int n_beats, input bit gaps,
                            output bit early_vld, output int err_at);
    logic [7:0] wd [5];
    wd[0] = wu; wd[1] = wv; wd[2] = ww; wd[3] = wx; wd[4] = wy;
    early_vld = 1'b0;
    err_at    = -1;
    for (int k = 0; k < n_beats; k++) begin
      do_beat(wd[k % 5][7 - (k / 5)], (k == 0) ? first_sync : 1'b0);
      if (out_vld && k < 39) early_vld = 1'b1;
      if (sync_err && err_at < 0) err_at = k;
      if (gaps && ((k + 1) % 3 == 0) && k < n_beats - 1) begin
        idle();
        if (out_vld && k < 39) early_vld = 1'b1;
        if (sync_err && err_at < 0) err_at = k;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m = 1'b0; m_vld = 1'b0; sync = 1'b0; out_rdy = 1'b0;
    step();
    step();
    chk_cnt++;
    if ({u_o, v_o, w_o, x_o, y_o} !== 40'h0) $display("FAIL reset_words got=%h exp=0", {u_o, v_o, w_o, x_o, y_o});
    else pass_cnt++;
    chk_cnt++;
    if ({out_vld, sync_err, ovf} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {out_vld, sync_err, ovf});
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    bit ev; int ea;
    out_rdy = 1'b1;
    send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 1'b1, 40, 1'b0, ev, ea);
    chk_cnt++;
    if (out_vld !== 1'b1 || ev) $display("FAIL basic_vld got=%b early=%0d exp=1 early=0", out_vld, ev);
    else pass_cnt++;
    chk_cnt++;
    if ({u_o, v_o, w_o, x_o, y_o} !== 40'hA53C0FF081) $display("FAIL basic_words got=%h exp=a53c0ff081", {u_o, v_o, w_o, x_o, y_o});
    else pass_cnt++;
    idle();
    chk_cnt++;
    if ({out_vld, sync_err, ovf} !== 3'b000 || ea != -1) $display("FAIL basic_after got=%b err_at=%0d exp=000 err_at=-1", {out_vld, sync_err, ovf}, ea);
    else pass_cnt++;
  endtask

  task automatic test_gapped();
    bit ev; int ea;
    out_rdy = 1'b1;
    send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 1'b1, 40, 1'b1, ev, ea);
    chk_cnt++;
    if (out_vld !== 1'b1 || ev || ea != -1) $display("FAIL gapped_vld got=%b early=%0d err_at=%0d exp=1 0 -1", out_vld, ev, ea);
    else pass_cnt++;
    chk_cnt++;
    if ({u_o, v_o, w_o, x_o, y_o} !== 40'hA53C0FF081) $display("FAIL gapped_words got=%h exp=a53c0ff081", {u_o, v_o, w_o, x_o, y_o});
    else pass_cnt++;
    idle();
  endtask

  task automatic test_hunt();
    bit ev; int ea; bit vld_seen;
    do_reset();
    out_rdy  = 1'b1;
    vld_seen = 1'b0;
    for (int k = 0; k < 7; k++) begin
      do_beat(1'($urandom_range(0, 1)), 1'b0);
      if (out_vld) vld_seen = 1'b1;
    end
    send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 1'b1, 40, 1'b0, ev, ea);
    chk_cnt++;
    if ({u_o, v_o, w_o, x_o, y_o} !== 40'hA53C0FF081 || out_vld !== 1'b1) $display("FAIL hunt_words got=%h vld=%b exp=a53c0ff081 vld=1", {u_o, v_o, w_o, x_o, y_o}, out_vld);
    else pass_cnt++;
    idle();
    chk_cnt++;
    if (vld_seen || ev || out_vld !== 1'b0) $display("FAIL hunt_single got pre=%0d early=%0d vld=%b exp 0 0 0", vld_seen, ev, out_vld);
    else pass_cnt++;
  endtask

  task automatic test_slip();
    bit ev1, ev2; int ea1, ea2;
    out_rdy = 1'b1;
    send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 1'b1, 13, 1'b0, ev1, ea1);
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 1'b1, 40, 1'b0, ev2, ea2);
    chk_cnt++;
    if (ea1 != -1 || ea2 != 0) $display("FAIL slip_err got err_at=%0d/%0d exp=-1/0", ea1, ea2);
    else pass_cnt++;
    chk_cnt++;
    if (ev1 || ev2 || out_vld !== 1'b1) $display("FAIL slip_vld got early=%0d/%0d vld=%b exp=0/0 vld=1", ev1, ev2, out_vld);
    else pass_cnt++;
    chk_cnt++;
    if ({u_o, v_o, w_o, x_o, y_o} !== 40'h1122334455) $display("FAIL slip_words got=%h exp=1122334455", {u_o, v_o, w_o, x_o, y_o});
    else pass_cnt++;
    idle();
  endtask

  task automatic test_overrun();
    bit ev; int ea;
    do_reset();
    out_rdy = 1'b0;
    send_frame(8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 1'b1, 40, 1'b0, ev, ea);
    chk_cnt++;
    if ({out_vld, ovf} !== 2'b10) $display("FAIL ovr_first got vld,ovf=%b exp=10", {out_vld, ovf});
    else pass_cnt++;
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 1'b0, 40, 1'b0, ev, ea);
    chk_cnt++;
    if ({u_o, v_o, w_o, x_o, y_o} !== 40'h0102030405) $display("FAIL ovr_words got=%h exp=0102030405", {u_o, v_o, w_o, x_o, y_o});
    else pass_cnt++;
    chk_cnt++;
    if ({out_vld, ovf} !== 2'b11) $display("FAIL ovr_flag got vld,ovf=%b exp=11", {out_vld, ovf});
    else pass_cnt++;
    out_rdy = 1'b1;
    idle();
    out_rdy = 1'b0;
    idle();
    idle();
    chk_cnt++;
    if ({out_vld, ovf} !== 2'b01) $display("FAIL ovr_sticky got vld,ovf=%b exp=01", {out_vld, ovf});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit ev; int ea;
    out_rdy = 1'b0;
    send_frame(8'hC3, 8'h96, 8'h5A, 8'h69, 8'hE7, 1'b1, 40, 1'b0, ev, ea);
    chk_cnt++;
    if ({u_o, v_o, w_o, x_o, y_o} !== 40'hC3965A69E7 || out_vld !== 1'b1) $display("FAIL mid_pre got=%h vld=%b exp=c3965a69e7 vld=1", {u_o, v_o, w_o, x_o, y_o}, out_vld);
    else pass_cnt++;
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 20, 1'b0, ev, ea);
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({u_o, v_o, w_o, x_o, y_o} !== 40'h0 || {out_vld, sync_err, ovf} !== 3'b000) $display("FAIL mid_async got=%h flags=%b exp=0 000", {u_o, v_o, w_o, x_o, y_o}, {out_vld, sync_err, ovf});
    else pass_cnt++;
    step();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    send_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 40, 1'b0, ev, ea);
    idle();
    chk_cnt++;
    if (ev || out_vld !== 1'b0 || {u_o, v_o, w_o, x_o, y_o} !== 40'h0) $display("FAIL mid_hunt got early=%0d vld=%b words=%h exp 0 0 0", ev, out_vld, {u_o, v_o, w_o, x_o, y_o});
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_hunt();
    test_slip();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
